// File: rtl/mm_arbiter.sv
// mm_arbiter: shares one main-memory port between instruction fetch (I), data (D) and loader (L); L has absolute priority, I/D alternate round-robin; optional stats counters under MM_ARB_STATS_EN
module mm_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WR_W = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I_REQ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic              I_ACK,
  output logic [DATA_W-1:0] I_DATA,
  input  logic              D_REQ,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [WR_W-1:0]   D_WR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic              D_ACK,
  output logic [DATA_W-1:0] D_RDATA,
  input  logic              L_REQ,
  input  logic [ADDR_W-1:0] L_ADDR,
  input  logic [DATA_W-1:0] L_WDATA,
  output logic              L_ACK,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [WR_W-1:0]   M_WR,
  output logic [DATA_W-1:0] M_WDATA,
  input  logic [DATA_W-1:0] M_RDATA,
  output logic              CPU_HOLD
`ifdef MM_ARB_STATS_EN
  ,
  output logic [31:0]       STAT_I_GRANTS,
  output logic [31:0]       STAT_D_GRANTS,
  output logic [31:0]       STAT_WAIT_CYC
`endif
);
  localparam logic [WR_W-1:0] MM_WR_W = {WR_W{1'b1}};
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {OWN_I, OWN_D, OWN_L} own_t;
  state_t state, state_nxt;
  own_t owner, gnt;
  logic gnt_vld, rr_d, rd_pend;
  logic [ADDR_W-1:0] addr_nxt;
  logic [WR_W-1:0] wr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  always_comb begin
    gnt_vld = L_REQ | I_REQ | D_REQ;
    gnt = L_REQ ? OWN_L : (I_REQ && (!D_REQ || !rr_d)) ? OWN_I : OWN_D;
    addr_nxt = gnt == OWN_L ? L_ADDR : gnt == OWN_I ? I_ADDR : D_ADDR;
    wr_nxt = gnt == OWN_L ? MM_WR_W : gnt == OWN_I ? '0 : D_WR;
    wdata_nxt = gnt == OWN_L ? L_WDATA : gnt == OWN_I ? '0 : D_WDATA;
    state_nxt = state == IDLE ? (gnt_vld ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      owner <= OWN_I;
      rr_d <= 1'b0;
      rd_pend <= 1'b0;
      M_ADDR <= '0;
      M_WR <= '0;
      M_WDATA <= '0;
      I_ACK <= 1'b0;
      D_ACK <= 1'b0;
      L_ACK <= 1'b0;
      I_DATA <= '0;
      D_RDATA <= '0;
      CPU_HOLD <= 1'b1;
    end else begin
      I_ACK <= 1'b0;
      D_ACK <= 1'b0;
      L_ACK <= 1'b0;
      if (state == IDLE) begin
        CPU_HOLD <= L_REQ;
        if (gnt_vld) begin
          owner <= gnt;
          rd_pend <= wr_nxt == '0;
          M_ADDR <= addr_nxt;
          M_WR <= wr_nxt;
          M_WDATA <= wdata_nxt;
        end
      end
      // Write strobe lasts only the ACCESS cycle so the store commits once
      if (state == ACCESS) M_WR <= '0;
      if (state == RESP) begin
        I_ACK <= owner == OWN_I;
        D_ACK <= owner == OWN_D;
        L_ACK <= owner == OWN_L;
        if (owner == OWN_I) I_DATA <= M_RDATA;
        if (owner == OWN_D && rd_pend) D_RDATA <= M_RDATA;
        if (owner == OWN_I) rr_d <= 1'b1;
        if (owner == OWN_D) rr_d <= 1'b0;
      end
    end
  end
`ifdef MM_ARB_STATS_EN
  logic i_busy, d_busy, wait_cyc;
  always_comb begin
    i_busy = state == IDLE ? (gnt_vld && gnt == OWN_I) : owner == OWN_I;
    d_busy = state == IDLE ? (gnt_vld && gnt == OWN_D) : owner == OWN_D;
    wait_cyc = (I_REQ && !I_ACK && !i_busy) || (D_REQ && !D_ACK && !d_busy);
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      STAT_I_GRANTS <= '0;
      STAT_D_GRANTS <= '0;
      STAT_WAIT_CYC <= '0;
    end else begin
      if (state == IDLE && gnt_vld && gnt == OWN_I) STAT_I_GRANTS <= STAT_I_GRANTS + 32'd1;
      if (state == IDLE && gnt_vld && gnt == OWN_D) STAT_D_GRANTS <= STAT_D_GRANTS + 32'd1;
      if (wait_cyc) STAT_WAIT_CYC <= STAT_WAIT_CYC + 32'd1;
    end
  end
`endif
endmodule

// File: doc/mm_arbiter.md
Name: mm_arbiter

Overview:
- Shares the single main-memory (mm) access port between three requesters: CPU instruction fetch (I), CPU data load/store (D) and a boot/debug loader (L).
- Sits between risc_v_32 and mm in computer_simulator.
- Uses req/ack handshakes and round-robin arbitration between I and D; L has absolute priority.
- The mm read path is treated as registered, with 1-cycle read latency.

Parameters:
- ADDR_W, 32, address width of all requesters and mm.
- DATA_W, 32, data width.
- WR_W, 2, width of write-type code; MM_WR_* encoding from defs.v, 2'b00 = read/no write.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- I_REQ  in  1  fetch request.
- I_ADDR  in  ADDR_W  fetch address.
- I_ACK  out  1  one-cycle pulse; I_DATA valid this cycle.
- I_DATA  out  DATA_W  fetched instruction.
- D_REQ  in  1  data request.
- D_ADDR  in  ADDR_W  data address.
- D_WR  in  WR_W  write type; 00 = read.
- D_WDATA  in  DATA_W  store data.
- D_ACK  out  1  one-cycle pulse; D_RDATA valid (reads) or write committed.
- D_RDATA  out  DATA_W  load data.
- L_REQ  in  1  loader request; writes only.
- L_ADDR  in  ADDR_W  loader address.
- L_WDATA  in  DATA_W  loader data.
- L_ACK  out  1  one-cycle pulse; write committed.
- M_ADDR  out  ADDR_W  to mm address.
- M_WR  out  WR_W  to mm write type.
- M_WDATA  out  DATA_W  to mm write data.
- M_RDATA  in  DATA_W  from mm; valid the cycle after M_ADDR is presented with M_WR=00.
- CPU_HOLD  out  1  high while L owns memory; the CPU stalls its PC.

Behaviour:
- Reset:
  - State = IDLE; all ACKs = 0; M_WR = 00; M_ADDR = 0; M_WDATA = 0; I_DATA and D_RDATA = 0.
  - CPU_HOLD = 1; it stays 1 until the first cycle after reset in which L_REQ = 0.
  - Round-robin pointer = I.
- Requests are level-held: a requester keeps REQ high with stable address/data until it sees its ACK. It may drop REQ the cycle after ACK, or keep it high to issue back-to-back accesses.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: sample requests at a clock edge. Priority is L > (I/D round-robin). The winner's address, write code and data are registered onto M_* and the FSM goes to ACCESS. With no request, stay in IDLE with M_WR = 00.
  - ACCESS: mm performs the access this cycle; go to RESP.
  - RESP: pulse the winner's ACK.
    - For reads, M_RDATA is registered into I_DATA or D_RDATA in the same cycle ACK is high.
    - Force M_WR = 00, so a write commits exactly once.
    - Toggle the round-robin pointer away from the winner if the winner was I or D.
    - Return to IDLE.
- Latency: REQ seen at edge N gives ACK high in cycle N+2. Maximum throughput is one access per 3 cycles.
- I_DATA and D_RDATA hold their last value until the next ACK for that port.
- L requests with L_REQ: the arbiter treats them as M_WR = MM_WR_W.
- CPU_HOLD:
  - Rises at the edge that grants L.
  - Falls in the first IDLE cycle with L_REQ = 0.
  - An I or D access already in flight completes before L is granted.
- Simultaneous I and D with pointer = I: I wins, then D is granted on the next IDLE. Neither requester waits more than one access behind the other.
- A REQ that drops before its ACK is a protocol error. The arbiter takes no action; an access already registered completes and ACK still pulses.
- An async RST mid-access returns to the reset state immediately. No ACK is issued; any partial write is the requester's concern.
- Address and data pass through unmodified; there are no alignment checks.

Optional Feature:
- Macro: MM_ARB_STATS_EN.
- When defined, adds output ports STAT_I_GRANTS, STAT_D_GRANTS and STAT_WAIT_CYC (all 32 bit). These count I grants, D grants, and cycles where I_REQ or D_REQ is high without that port being granted or acknowledged. Counters reset to 0 on RST and wrap modulo 2^32.
- When undefined, these ports and counters do not exist, and the FSM and the rest of the design behave identically.

Test Plan:
- Reset with L_REQ = 0, then I_REQ at address 0x0 with mm[0] = {20'd5, 5'd3, OP_LUI} -> I_ACK at edge+2 with I_DATA = 0x000051B7. CPU_HOLD is 0 after the first IDLE.
- L writes 0x00000001 to address 0x10, then D reads 0x10 -> L_ACK once with M_WR = MM_WR_W for exactly one cycle; D_RDATA = 0x00000001; CPU_HOLD is 1 during the L access.
- I_REQ and D_REQ held continuously -> grants alternate I, D, I, D, with each ACK exactly 3 cycles apart.
- L_REQ asserted while a D access is in ACCESS -> D completes with D_ACK, L is granted next, and no I grant occurs in between.
- RST pulsed during an ACCESS cycle -> outputs return to reset values asynchronously, no ACK fires, M_WR = 00.
- With MM_ARB_STATS_EN defined, 4 I accesses and 2 D accesses under contention -> STAT_I_GRANTS = 4, STAT_D_GRANTS = 2, STAT_WAIT_CYC nonzero and matching the bench count.
